alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
- REQ-001 Parameter XLEN, default 32: data width of all operand and result buses.
- REQ-002 Parameter BUBBLE_OP, default 4'd5: AluOP value driven during bubbles (ADD).
- REQ-003 clk  in  1: single clock; all state updates on its rising edge.
- REQ-004 rst  in  1: reset, asynchronous and active-high.
- REQ-005 in_valid  in  1: decode stage presents a valid instruction.
- REQ-006 stall  in  1: hold all stage registers this cycle.
- REQ-007 flush  in  1: replace the stage contents with a bubble this cycle.
- REQ-008 id_AluOP  in  4: ALU operation code for the decoded instruction.
- REQ-009 id_rs1_data, id_rs2_data  in  XLEN: register-file read values.
- REQ-010 id_imm  in  XLEN: sign-extended immediate.
- REQ-011 id_AluSrc  in  1: 1 selects id_imm as Y, 0 selects the rs2 operand.
- REQ-012 id_rs1, id_rs2, id_rd  in  5: source and destination register numbers.
- REQ-013 id_RegWrite  in  1: the instruction writes rd.
- REQ-014 exmem_rd  in  5, exmem_RegWrite  in  1, exmem_result  in  XLEN: EX/MEM forwarding source.
- REQ-015 memwb_rd  in  5, memwb_RegWrite  in  1, memwb_result  in  XLEN: MEM/WB forwarding source.
- REQ-016 ex_valid  out  1: the stage holds a valid instruction.
- REQ-017 ex_AluOP  out  4: registered operation code, drives ALU AluOP.
- REQ-018 ex_X, ex_Y  out  XLEN: registered operands, drive ALU X and Y.
- REQ-019 ex_store_data  out  XLEN: registered forwarded rs2 value, for stores.
- REQ-020 ex_rd  out  5, ex_RegWrite  out  1: registered destination information.

Function
- REQ-021 Forwarding SHALL be resolved combinationally in the decode stage; the forwarded operand is what gets latched.
- REQ-022 Per source s (rs1, rs2):
  - EX/MEM: if exmem_RegWrite and exmem_rd==s and s!=0, use exmem_result.
  - MEM/WB: else if memwb_RegWrite and memwb_rd==s and s!=0, use memwb_result.
  - Otherwise use id_rsN_data.
- REQ-023 EX/MEM SHALL take priority over MEM/WB when both match.
- REQ-024 Register x0 SHALL never be forwarded; its operand is id_rsN_data.
- REQ-025 X SHALL be the forwarded rs1 operand.
- REQ-026 Y SHALL be id_imm when id_AluSrc=1, else the forwarded rs2 operand.
- REQ-027 ex_store_data SHALL always take the forwarded rs2 operand.
- REQ-028 Normal load: with flush=0, stall=0 and in_valid=1, all outputs SHALL load next-edge values with ex_valid=1; latency is one cycle.
- REQ-029 in_valid=0 with flush=0 and stall=0 SHALL load a bubble.
- REQ-030 Bubble contents SHALL be: ex_valid=0, ex_RegWrite=0, ex_AluOP=BUBBLE_OP, ex_X=0, ex_Y=0, ex_store_data=0, ex_rd=0.
- REQ-031 stall=1 with flush=0 SHALL hold every output register unchanged, including ex_valid.
- REQ-032 flush=1 SHALL load a bubble regardless of stall and in_valid; flush wins over stall.
- REQ-033 The stage has two states, VALID and BUBBLE, reflected by ex_valid; transitions follow REQ-028 to REQ-032.
- REQ-034 No output SHALL depend combinationally on any input; all outputs are flop outputs.

Reset
- REQ-035 rst=1 SHALL asynchronously force the bubble contents of REQ-030 on all outputs, without waiting for a clock edge.
- REQ-036 Outputs SHALL hold the bubble for as long as rst=1; the first load after rst deasserts takes place on the next rising edge.
- REQ-037 Reset asserted mid-stall or mid-flush SHALL override both.

Structure
- REQ-038 A shared package SHALL hold XLEN, the AluOP encodings (BUBBLE_OP = ADD = 5) and the register-number width of 5.
- REQ-039 One sub-module, fwd_select, SHALL implement the per-operand forwarding priority mux; it is instantiated twice.

Verification
- REQ-040 Reset: assert rst between clock edges -> all outputs immediately show the bubble contents, ex_AluOP=5.
- REQ-041 Forwarding priority: rs1=3, exmem_rd=3, exmem_result=0x11, memwb_rd=3, memwb_result=0x22, both RegWrite=1 -> ex_X=0x11 one cycle later.
- REQ-042 x0 is not forwarded: rs2=0, exmem_rd=0, exmem_RegWrite=1, exmem_result=0xFF, id_rs2_data=0, AluSrc=0 -> ex_Y=0.
- REQ-043 Immediate select: AluSrc=1, imm=0xFFFFFFFC, rs2 forwarded value 0x7 -> ex_Y=0xFFFFFFFC and ex_store_data=0x7.
- REQ-044 Stall hold: load X=0x5, then stall=1 for 3 cycles with changing inputs -> ex_X stays 0x5 and ex_valid stays 1.
- REQ-045 Flush over stall: stall=1 and flush=1 together -> next cycle ex_valid=0, ex_RegWrite=0, ex_X=0.

Source files
------------

// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU operand stage: widths, AluOP encodings,
// stage state and the forwarding-hit helper.
package alu_operand_stage_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SRL  = 4'd4;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [0:0] {
    ST_BUBBLE = 1'b0,
    ST_VALID  = 1'b1
  } stage_state_e;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } stage_action_e;

  // A producer forwards only when it writes a non-zero register matching the source.
  function automatic logic fwd_hit(input logic we,
                                   input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] src);
    return we && (dst == src) && (src != {REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// Per-operand forwarding mux: EX/MEM result over MEM/WB result over the
// register-file read value.
module fwd_select #(
  parameter int XLEN = alu_operand_stage_pkg::XLEN
) (
  input  logic [alu_operand_stage_pkg::REG_W-1:0] src,
  input  logic [XLEN-1:0]                         rf_data,
  input  logic [alu_operand_stage_pkg::REG_W-1:0] exmem_rd,
  input  logic                                    exmem_we,
  input  logic [XLEN-1:0]                         exmem_result,
  input  logic [alu_operand_stage_pkg::REG_W-1:0] memwb_rd,
  input  logic                                    memwb_we,
  input  logic [XLEN-1:0]                         memwb_result,
  output logic [XLEN-1:0]                         fwd_data
);
  import alu_operand_stage_pkg::*;

  // Priority select of the operand source
  always_comb begin
    fwd_data = rf_data;
    if (fwd_hit(exmem_we, exmem_rd, src)) begin
      fwd_data = exmem_result;
    end else if (fwd_hit(memwb_we, memwb_rd, src)) begin
      fwd_data = memwb_result;
    end else begin
      fwd_data = rf_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand register: resolves forwarding in decode and latches the ALU
// operands, store data and destination info, with stall, flush and bubbles.
module alu_operand_stage #(
  parameter int         XLEN      = alu_operand_stage_pkg::XLEN,
  parameter logic [3:0] BUBBLE_OP = alu_operand_stage_pkg::ALU_ADD
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  input  logic                                    stall,
  input  logic                                    flush,
  input  logic [3:0]                              id_AluOP,
  input  logic [XLEN-1:0]                         id_rs1_data,
  input  logic [XLEN-1:0]                         id_rs2_data,
  input  logic [XLEN-1:0]                         id_imm,
  input  logic                                    id_AluSrc,
  input  logic [alu_operand_stage_pkg::REG_W-1:0] id_rs1,
  input  logic [alu_operand_stage_pkg::REG_W-1:0] id_rs2,
  input  logic [alu_operand_stage_pkg::REG_W-1:0] id_rd,
  input  logic                                    id_RegWrite,
  input  logic [alu_operand_stage_pkg::REG_W-1:0] exmem_rd,
  input  logic                                    exmem_RegWrite,
  input  logic [XLEN-1:0]                         exmem_result,
  input  logic [alu_operand_stage_pkg::REG_W-1:0] memwb_rd,
  input  logic                                    memwb_RegWrite,
  input  logic [XLEN-1:0]                         memwb_result,
  output logic                                    ex_valid,
  output logic [3:0]                              ex_AluOP,
  output logic [XLEN-1:0]                         ex_X,
  output logic [XLEN-1:0]                         ex_Y,
  output logic [XLEN-1:0]                         ex_store_data,
  output logic [alu_operand_stage_pkg::REG_W-1:0] ex_rd,
  output logic                                    ex_RegWrite
);
  import alu_operand_stage_pkg::*;

  logic [XLEN-1:0]  rs1_fwd_s;
  logic [XLEN-1:0]  rs2_fwd_s;
  logic [XLEN-1:0]  y_sel_s;
  stage_action_e    action_s;
  stage_state_e     state_r;
  stage_state_e     state_nx_s;

  logic [3:0]       alu_op_r,    alu_op_nx_s;
  logic [XLEN-1:0]  x_r,         x_nx_s;
  logic [XLEN-1:0]  y_r,         y_nx_s;
  logic [XLEN-1:0]  sd_r,        sd_nx_s;
  logic [REG_W-1:0] rd_r,        rd_nx_s;
  logic             regwrite_r,  regwrite_nx_s;

  fwd_select #(.XLEN(XLEN)) u_fwd_rs1 (
    .src          (id_rs1),
    .rf_data      (id_rs1_data),
    .exmem_rd     (exmem_rd),
    .exmem_we     (exmem_RegWrite),
    .exmem_result (exmem_result),
    .memwb_rd     (memwb_rd),
    .memwb_we     (memwb_RegWrite),
    .memwb_result (memwb_result),
    .fwd_data     (rs1_fwd_s)
  );

  fwd_select #(.XLEN(XLEN)) u_fwd_rs2 (
    .src          (id_rs2),
    .rf_data      (id_rs2_data),
    .exmem_rd     (exmem_rd),
    .exmem_we     (exmem_RegWrite),
    .exmem_result (exmem_result),
    .memwb_rd     (memwb_rd),
    .memwb_we     (memwb_RegWrite),
    .memwb_result (memwb_result),
    .fwd_data     (rs2_fwd_s)
  );

  // Y operand: immediate or forwarded rs2
  always_comb begin
    y_sel_s = rs2_fwd_s;
    if (id_AluSrc) begin
      y_sel_s = id_imm;
    end else begin
      y_sel_s = rs2_fwd_s;
    end
  end

  // Stage control decision; flush outranks stall
  always_comb begin
    action_s = ACT_BUBBLE;
    if (flush) begin
      action_s = ACT_BUBBLE;
    end else if (stall) begin
      action_s = ACT_HOLD;
    end else if (in_valid) begin
      action_s = ACT_LOAD;
    end else begin
      action_s = ACT_BUBBLE;
    end
  end

  // Next-state and next-contents logic for the VALID/BUBBLE stage machine
  always_comb begin
    state_nx_s    = state_r;
    alu_op_nx_s   = alu_op_r;
    x_nx_s        = x_r;
    y_nx_s        = y_r;
    sd_nx_s       = sd_r;
    rd_nx_s       = rd_r;
    regwrite_nx_s = regwrite_r;
    case (action_s)
      ACT_LOAD: begin
        state_nx_s    = ST_VALID;
        alu_op_nx_s   = id_AluOP;
        x_nx_s        = rs1_fwd_s;
        y_nx_s        = y_sel_s;
        sd_nx_s       = rs2_fwd_s;
        rd_nx_s       = id_rd;
        regwrite_nx_s = id_RegWrite;
      end
      ACT_HOLD: begin
        state_nx_s    = state_r;
        alu_op_nx_s   = alu_op_r;
        x_nx_s        = x_r;
        y_nx_s        = y_r;
        sd_nx_s       = sd_r;
        rd_nx_s       = rd_r;
        regwrite_nx_s = regwrite_r;
      end
      ACT_BUBBLE: begin
        state_nx_s    = ST_BUBBLE;
        alu_op_nx_s   = BUBBLE_OP;
        x_nx_s        = {XLEN{1'b0}};
        y_nx_s        = {XLEN{1'b0}};
        sd_nx_s       = {XLEN{1'b0}};
        rd_nx_s       = {REG_W{1'b0}};
        regwrite_nx_s = 1'b0;
      end
      default: begin
        state_nx_s    = ST_BUBBLE;
        alu_op_nx_s   = BUBBLE_OP;
        x_nx_s        = {XLEN{1'b0}};
        y_nx_s        = {XLEN{1'b0}};
        sd_nx_s       = {XLEN{1'b0}};
        rd_nx_s       = {REG_W{1'b0}};
        regwrite_nx_s = 1'b0;
      end
    endcase
  end

  // Stage registers; reset forces the bubble immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_BUBBLE;
      alu_op_r   <= BUBBLE_OP;
      x_r        <= {XLEN{1'b0}};
      y_r        <= {XLEN{1'b0}};
      sd_r       <= {XLEN{1'b0}};
      rd_r       <= {REG_W{1'b0}};
      regwrite_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      alu_op_r   <= alu_op_nx_s;
      x_r        <= x_nx_s;
      y_r        <= y_nx_s;
      sd_r       <= sd_nx_s;
      rd_r       <= rd_nx_s;
      regwrite_r <= regwrite_nx_s;
    end
  end

  assign ex_valid      = (state_r == ST_VALID);
  assign ex_AluOP      = alu_op_r;
  assign ex_X          = x_r;
  assign ex_Y          = y_r;
  assign ex_store_data = sd_r;
  assign ex_rd         = rd_r;
  assign ex_RegWrite   = regwrite_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: a forwarding/stage reference model
// predicts the stage contents after every edge; a negedge monitor compares.
module tb_alu_operand_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, stall, flush;
  logic [3:0]      id_AluOP;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic            id_AluSrc;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_RegWrite;
  logic [4:0]      exmem_rd;
  logic            exmem_RegWrite;
  logic [XLEN-1:0] exmem_result;
  logic [4:0]      memwb_rd;
  logic            memwb_RegWrite;
  logic [XLEN-1:0] memwb_result;
  logic            ex_valid;
  logic [3:0]      ex_AluOP;
  logic [XLEN-1:0] ex_X, ex_Y, ex_store_data;
  logic [4:0]      ex_rd;
  logic            ex_RegWrite;

  alu_operand_stage #(.XLEN(XLEN), .BUBBLE_OP(4'd5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .id_AluOP(id_AluOP), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_AluSrc(id_AluSrc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_RegWrite(id_RegWrite),
    .exmem_rd(exmem_rd), .exmem_RegWrite(exmem_RegWrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_RegWrite(memwb_RegWrite), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_AluOP(ex_AluOP), .ex_X(ex_X), .ex_Y(ex_Y),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            v;
    logic            rw;
    logic [3:0]      op;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [XLEN-1:0] sd;
    logic [4:0]      rd;
  } exp_t;

  exp_t q[$];
  exp_t model;
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t bubble();
    exp_t b;
    b.v = 1'b0; b.rw = 1'b0; b.op = 4'd5;
    b.x = 32'd0; b.y = 32'd0; b.sd = 32'd0; b.rd = 5'd0;
    return b;
  endfunction

  // Value an instruction actually sees for source register s
  function automatic logic [XLEN-1:0] operand(input logic [4:0] s, input logic [XLEN-1:0] rf);
    if (s == 5'd0) return rf;
    if (exmem_RegWrite && exmem_rd == s) return exmem_result;
    if (memwb_RegWrite && memwb_rd == s) return memwb_result;
    return rf;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic rand_inputs();
    in_valid       = ($urandom_range(0, 3) != 0);
    stall          = ($urandom_range(0, 3) == 0);
    flush          = ($urandom_range(0, 7) == 0);
    id_AluOP       = 4'($urandom_range(0, 15));
    id_rs1_data    = $urandom;
    id_rs2_data    = $urandom;
    id_imm         = $urandom;
    id_AluSrc      = 1'($urandom_range(0, 1));
    id_rs1         = 5'($urandom_range(0, 3));
    id_rs2         = 5'($urandom_range(0, 3));
    id_rd          = 5'($urandom_range(0, 31));
    id_RegWrite    = 1'($urandom_range(0, 1));
    exmem_rd       = 5'($urandom_range(0, 3));
    exmem_RegWrite = 1'($urandom_range(0, 1));
    exmem_result   = $urandom;
    memwb_rd       = 5'($urandom_range(0, 3));
    memwb_RegWrite = 1'($urandom_range(0, 1));
    memwb_result   = $urandom;
  endtask

  // One rising edge: predict what the stage should now hold, queue it
  task automatic step();
    @(posedge clk);
    if (rst || flush) begin
      model = bubble();
    end else if (stall) begin
      model = model;
    end else if (in_valid) begin
      model.v  = 1'b1;
      model.rw = id_RegWrite;
      model.op = id_AluOP;
      model.x  = operand(id_rs1, id_rs1_data);
      model.sd = operand(id_rs2, id_rs2_data);
      model.y  = id_AluSrc ? id_imm : operand(id_rs2, id_rs2_data);
      model.rd = id_rd;
    end else begin
      model = bubble();
    end
    q.push_back(model);
    #1;
  endtask

  task automatic quiet();
    in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    id_AluOP = 4'd0; id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
    id_AluSrc = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd1; id_RegWrite = 1'b1;
    exmem_rd = 5'd0; exmem_RegWrite = 1'b0; exmem_result = 32'd0;
    memwb_rd = 5'd0; memwb_RegWrite = 1'b0; memwb_result = 32'd0;
  endtask

  // Monitor: compare the DUT against the oldest prediction
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("sb_valid", 32'(ex_valid), 32'(e.v));
      check("sb_regwrite", 32'(ex_RegWrite), 32'(e.rw));
      check("sb_aluop", 32'(ex_AluOP), 32'(e.op));
      check("sb_x", ex_X, e.x);
      check("sb_y", ex_Y, e.y);
      check("sb_store", ex_store_data, e.sd);
      check("sb_rd", 32'(ex_rd), 32'(e.rd));
    end
  end

  initial begin
    model = bubble();
    rst = 1'b1;
    quiet();
    #1;
    check("reset_aluop_async", 32'(ex_AluOP), 32'd5);
    check("reset_valid_async", 32'(ex_valid), 32'd0);
    step();
    step();
    rst = 1'b0;

    // EX/MEM beats MEM/WB on the same register
    quiet();
    id_rs1 = 5'd3; id_rs1_data = 32'h99;
    exmem_rd = 5'd3; exmem_RegWrite = 1'b1; exmem_result = 32'h11;
    memwb_rd = 5'd3; memwb_RegWrite = 1'b1; memwb_result = 32'h22;
    step();
    check("fwd_priority_x", ex_X, 32'h11);

    // x0 is never forwarded
    quiet();
    id_rs2 = 5'd0; id_rs2_data = 32'd0;
    exmem_rd = 5'd0; exmem_RegWrite = 1'b1; exmem_result = 32'hFF;
    memwb_rd = 5'd0; memwb_RegWrite = 1'b1; memwb_result = 32'hEE;
    step();
    check("x0_no_fwd_y", ex_Y, 32'd0);

    // Immediate selected for Y while store data keeps forwarded rs2
    quiet();
    id_AluSrc = 1'b1; id_imm = 32'hFFFF_FFFC;
    id_rs2 = 5'd4; id_rs2_data = 32'h1234;
    exmem_rd = 5'd4; exmem_RegWrite = 1'b1; exmem_result = 32'h7;
    step();
    check("imm_y", ex_Y, 32'hFFFF_FFFC);
    check("imm_store", ex_store_data, 32'h7);

    // Stall holds contents across changing inputs
    quiet();
    id_rs1 = 5'd6; id_rs1_data = 32'h5;
    step();
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      stall = 1'b1; flush = 1'b0;
      step();
      check("stall_x", ex_X, 32'h5);
      check("stall_valid", 32'(ex_valid), 32'd1);
    end

    // Flush wins over stall
    quiet();
    id_rs1 = 5'd7; id_rs1_data = 32'hABCD;
    step();
    stall = 1'b1; flush = 1'b1;
    step();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_regwrite", 32'(ex_RegWrite), 32'd0);
    check("flush_x", ex_X, 32'd0);

    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset in the middle of a stall, between edges
    quiet();
    id_rs1 = 5'd2; id_rs1_data = 32'h55AA;
    step();
    @(negedge clk);
    #2;
    stall = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(ex_valid), 32'd0);
    check("midrst_aluop", 32'(ex_AluOP), 32'd5);
    check("midrst_x", ex_X, 32'd0);
    step();
    rst = 1'b0;
    stall = 1'b0;
    step();
    check("post_reset_load", ex_X, 32'h55AA);

    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      step();
    end

    quiet();
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain actual=%0d required=0 pending", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
